// File: rtl/div_wb_arb_if.sv
// Divider-result / pipeline-writeback / register-file write bus for div_wb_arb.
// The arbiter is the slave. The EXU side and the register file together act as the master.
interface div_wb_arb_if #(
  parameter int XLEN = 32
) ();
  // divider result pulse
  logic            div_out_valid;
  logic [31:0]     div_out;
  logic [4:0]      div_out_addr;
  logic [XLEN-1:0] div_instr_tag;
  logic [31:0]     div_instr;
  // main pipeline writeback request
  logic            pipe_wb_valid;
  logic [4:0]      pipe_wb_addr;
  logic [31:0]     pipe_wb_data;
  logic [XLEN-1:0] pipe_instr_tag;
  logic [31:0]     pipe_instr;
  // register-file write port
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic [XLEN-1:0] wb_instr_tag;
  logic [31:0]     wb_instr;
  logic            wb_is_div;

  modport slave (
    input  div_out_valid, div_out, div_out_addr, div_instr_tag, div_instr,
    input  pipe_wb_valid, pipe_wb_addr, pipe_wb_data, pipe_instr_tag, pipe_instr,
    output rf_wen, rf_waddr, rf_wdata, wb_instr_tag, wb_instr, wb_is_div
  );

  modport master (
    output div_out_valid, div_out, div_out_addr, div_instr_tag, div_instr,
    output pipe_wb_valid, pipe_wb_addr, pipe_wb_data, pipe_instr_tag, pipe_instr,
    input  rf_wen, rf_waddr, rf_wdata, wb_instr_tag, wb_instr, wb_is_div
  );
endinterface

// File: rtl/div_wb_arb.sv
// Divide result writeback arbiter.
// Buffers divider results and shares the single RF write port with the main pipeline.
// It also tracks the in-flight divide destination for decode hazard stalls.

// One hazard comparator per decode source. It matches against the pending divide,
// the buffered results and the divide result currently in the write stage.
module div_wb_hz_lane #(
  parameter int DEPTH = 2
) (
  input  logic                  [4:0] src,
  input  logic                        pend_v,
  input  logic                  [4:0] pend_rd,
  input  logic [DEPTH-1:0]            ent_v,
  input  logic [DEPTH-1:0]      [4:0] ent_addr,
  input  logic                        wb_v,
  input  logic                  [4:0] wb_addr,
  output logic                        hit
);
  // x0 never creates a hazard
  always_comb begin
    hit = 1'b0;
    if (src != 5'd0) begin
      if (pend_v && pend_rd == src) hit = 1'b1;
      if (wb_v && wb_addr == src)   hit = 1'b1;
      for (int i = 0; i < DEPTH; i++)
        if (ent_v[i] && ent_addr[i] == src) hit = 1'b1;
    end
  end
endmodule

module div_wb_arb #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                div_issue,
  input  logic [4:0]          div_issue_rd,
  input  logic                flush_lower,
  div_wb_arb_if.slave         bus,
  input  logic [4:0]          idu_rs1_addr,
  input  logic [4:0]          idu_rs2_addr,
  input  logic [4:0]          idu_rd_addr,
  output logic                hazard_stall,
  output logic                div_issue_block,
  output logic                pipe_hold
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIM) + 1;
  localparam int NSRC = 3;

  typedef struct packed {
    logic [4:0]      addr;
    logic [31:0]     data;
    logic [XLEN-1:0] tag;
    logic [31:0]     instr;
  } ent_t;

  typedef enum logic [1:0] {SEL_IDLE, SEL_PIPE, SEL_BUF, SEL_BYP} sel_e;

  // scoreboard
  logic       pend_v;
  logic [4:0] pend_rd;

  // result buffer; the extra pointer bit tells full from empty
  ent_t             buf_q [DEPTH];
  logic [DEPTH-1:0] ent_v;
  logic [AW:0]      wr_ptr, rd_ptr, occ;
  logic             empty, full;

  // arbitration
  sel_e  sel;
  logic  pipe_own, div_ok, push, pop;
  ent_t  div_ent, head, wsrc;

  // registered write stage
  logic            wen_q, isdiv_q;
  logic [4:0]      waddr_q;
  logic [31:0]     wdata_q, instr_q;
  logic [XLEN-1:0] tag_q;

  logic [CW-1:0]   starve_cnt;

  assign occ   = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pipe_own = bus.pipe_wb_valid && (bus.pipe_wb_addr != 5'd0);
  assign div_ok   = bus.div_out_valid && (bus.div_out_addr != 5'd0);
  assign div_ent  = '{addr: bus.div_out_addr, data: bus.div_out,
                      tag: bus.div_instr_tag, instr: bus.div_instr};
  assign head     = buf_q[rd_ptr[AW-1:0]];

  // source priority: pipeline, then buffer head, then direct bypass of a fresh result
  always_comb begin
    sel = SEL_IDLE;
    if (pipe_own)    sel = SEL_PIPE;
    else if (!empty) sel = SEL_BUF;
    else if (div_ok) sel = SEL_BYP;
  end

  assign pop  = (sel == SEL_BUF);
  assign push = div_ok && (sel != SEL_BYP);

  // mux the selected source into the write stage
  always_comb begin
    wsrc = '{addr: bus.pipe_wb_addr, data: bus.pipe_wb_data,
             tag: bus.pipe_instr_tag, instr: bus.pipe_instr};
    case (sel)
      SEL_BUF: wsrc = head;
      SEL_BYP: wsrc = div_ent;
      default: ;
    endcase
  end

  // scoreboard: flush beats issue, and issue beats the result clearing it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v  <= 1'b0;
      pend_rd <= 5'd0;
    end else if (flush_lower) begin
      pend_v  <= 1'b0;
    end else if (div_issue) begin
      pend_v  <= 1'b1;
      pend_rd <= div_issue_rd;
    end else if (bus.div_out_valid) begin
      pend_v  <= 1'b0;
    end
  end

  // buffer pointers and per-entry valid bits (flush leaves committed entries alone)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ent_v  <= '0;
    end else begin
      if (pop) begin
        rd_ptr                 <= rd_ptr + 1'b1;
        ent_v[rd_ptr[AW-1:0]]  <= 1'b0;
      end
      if (push) begin
        wr_ptr                 <= wr_ptr + 1'b1;
        ent_v[wr_ptr[AW-1:0]]  <= 1'b1;
      end
    end
  end

  // buffer payload needs no reset; ent_v qualifies it
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr[AW-1:0]] <= div_ent;
  end

  // write stage: enable and source flag reset, data fields hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      isdiv_q <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      tag_q   <= '0;
      instr_q <= 32'd0;
    end else begin
      wen_q   <= (sel != SEL_IDLE);
      isdiv_q <= (sel == SEL_BUF) || (sel == SEL_BYP);
      if (sel != SEL_IDLE) begin
        waddr_q <= wsrc.addr;
        wdata_q <= wsrc.data;
        tag_q   <= wsrc.tag;
        instr_q <= wsrc.instr;
      end
    end
  end

  assign bus.rf_wen       = wen_q;
  assign bus.rf_waddr     = waddr_q;
  assign bus.rf_wdata     = wdata_q;
  assign bus.wb_instr_tag = tag_q;
  assign bus.wb_instr     = instr_q;
  assign bus.wb_is_div    = isdiv_q;

  // starvation counter: counts cycles a non-empty buffer is passed over, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                starve_cnt <= '0;
    else if (empty || pop)     starve_cnt <= '0;
    else if (starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
  end

  assign pipe_hold = (starve_cnt >= CW'(STARVE_LIM - 1));

  // a pending divide owns a slot it will land in, so count it as occupied
  logic [AW+1:0] occ_pend;
  assign occ_pend        = {1'b0, occ} + {{(AW+1){1'b0}}, pend_v};
  assign div_issue_block = (occ_pend >= (AW+2)'(DEPTH));

  // hazard lanes, one per decode source
  logic [DEPTH-1:0][4:0] ent_addr;
  logic [NSRC-1:0][4:0]  idu_src;
  logic [NSRC-1:0]       lane_hit;

  // flatten buffer addresses for the comparators
  always_comb begin
    ent_addr = '0;
    for (int i = 0; i < DEPTH; i++) ent_addr[i] = buf_q[i].addr;
  end

  assign idu_src = {idu_rd_addr, idu_rs2_addr, idu_rs1_addr};

  for (genvar g = 0; g < NSRC; g++) begin : g_hz
    div_wb_hz_lane #(.DEPTH(DEPTH)) u_lane (
      .src      (idu_src[g]),
      .pend_v   (pend_v),
      .pend_rd  (pend_rd),
      .ent_v    (ent_v),
      .ent_addr (ent_addr),
      .wb_v     (isdiv_q),
      .wb_addr  (waddr_q),
      .hit      (lane_hit[g])
    );
  end

  assign hazard_stall = |lane_hit;
endmodule

// File: tb/tb_div_wb_arb.sv
// Directed bench for div_wb_arb.
// A vector table drives one cycle per record. Each record's expectation is what
// should be visible in that cycle: combinational outputs for the current inputs,
// plus write-stage outputs from the previous edge. Hand sequences cover starvation,
// buffer fill and mid-cycle reset.
module tb_div_wb_arb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       div_issue, flush_lower;
  logic [4:0] div_issue_rd, rs1, rs2, rdd;
  logic       hazard_stall, div_issue_block, pipe_hold;
  int         checks = 0;
  int         errors = 0;

  div_wb_arb_if #(.XLEN(32)) bus ();

  div_wb_arb #(.XLEN(32), .DEPTH(2), .STARVE_LIM(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .div_issue       (div_issue),
    .div_issue_rd    (div_issue_rd),
    .flush_lower     (flush_lower),
    .bus             (bus),
    .idu_rs1_addr    (rs1),
    .idu_rs2_addr    (rs2),
    .idu_rd_addr     (rdd),
    .hazard_stall    (hazard_stall),
    .div_issue_block (div_issue_block),
    .pipe_hold       (pipe_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iss; logic [4:0] iss_rd; logic fl;
    logic        dv;  logic [4:0] da;     logic [31:0] dd;
    logic        pv;  logic [4:0] pa;     logic [31:0] pd;
    logic [4:0]  rs1, rs2, rd;
    logic        e_wen; logic [4:0] e_wa; logic [31:0] e_wd; logic e_div;
    logic        e_hz, e_blk, e_hold;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Tags and instruction words are derived from the data, so the source can be identified.
  task automatic drive(input vec_t v);
    div_issue          = v.iss;
    div_issue_rd       = v.iss_rd;
    flush_lower        = v.fl;
    bus.div_out_valid  = v.dv;
    bus.div_out_addr   = v.da;
    bus.div_out        = v.dd;
    bus.div_instr_tag  = v.dd + 32'h100;
    bus.div_instr      = v.dd ^ 32'hDEAD0000;
    bus.pipe_wb_valid  = v.pv;
    bus.pipe_wb_addr   = v.pa;
    bus.pipe_wb_data   = v.pd;
    bus.pipe_instr_tag = v.pd + 32'h200;
    bus.pipe_instr     = v.pd ^ 32'hBEEF0000;
    rs1 = v.rs1; rs2 = v.rs2; rdd = v.rd;
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0};
    return v;
  endfunction

  // Any push into a full buffer is a design error.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dut.push && dut.full) begin
      errors++;
      $display("FAIL push_full buffer push while full (t=%0t)", $time);
    end
  end

  initial begin
    vec_t v;
    // iss rd fl | dv da dd | pv pa pd | rs1 rs2 rd | wen wa wd div | hz blk hold
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     0,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{1,5,0, 0,0,0,       0,0,0,     0,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     5,0,0,   0,0,0,0,           1,0,0});
    vq.push_back('{0,0,0, 1,5,7,       0,0,0,     5,0,0,   0,0,0,0,           1,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     5,0,0,   1,5,7,1,           1,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     5,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{0,0,0, 0,0,0,       1,3,'h33,  0,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{0,0,0, 1,9,'h1234,  1,3,'h33,  0,0,0,   1,3,'h33,0,        0,0,0});
    vq.push_back('{0,0,0, 0,0,0,       1,3,'h33,  0,9,0,   1,3,'h33,0,        1,0,0});
    vq.push_back('{0,0,0, 0,0,0,       1,3,'h33,  0,9,0,   1,3,'h33,0,        1,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     0,9,0,   1,3,'h33,0,        1,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     0,9,0,   1,9,'h1234,1,      1,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     0,9,0,   0,0,0,0,           0,0,0});
    vq.push_back('{1,0,0, 0,0,0,       0,0,0,     0,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{0,0,0, 1,0,'h55,    0,0,0,     0,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     0,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{1,4,0, 0,0,0,       0,0,0,     0,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{0,0,1, 0,0,0,       0,0,0,     0,0,4,   0,0,0,0,           1,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     0,0,4,   0,0,0,0,           0,0,0});
    vq.push_back('{1,6,1, 0,0,0,       0,0,0,     0,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     6,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{1,8,0, 0,0,0,       0,0,0,     0,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{1,10,0, 1,8,'h88,   0,0,0,     0,0,0,   0,0,0,0,           0,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     10,0,0,  1,8,'h88,1,        1,0,0});
    vq.push_back('{0,0,0, 1,10,'hAA,   0,0,0,     10,0,0,  0,0,0,0,           1,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     10,0,0,  1,10,'hAA,1,       1,0,0});
    vq.push_back('{0,0,0, 0,0,0,       0,0,0,     10,0,0,  0,0,0,0,           0,0,0});

    // reset state
    rst_n = 1'b0;
    drive(idle());
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wen",   {31'd0, bus.rf_wen},        32'd0);
    chk("rst_isdiv", {31'd0, bus.wb_is_div},     32'd0);
    chk("rst_wdata", bus.rf_wdata,               32'd0);
    chk("rst_block", {31'd0, div_issue_block},   32'd0);
    chk("rst_hold",  {31'd0, pipe_hold},         32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // table-driven cycles
    foreach (vq[i]) begin
      @(posedge clk); #1 drive(vq[i]);
      @(negedge clk);
      chk($sformatf("v%0d_wen", i),   {31'd0, bus.rf_wen},      {31'd0, vq[i].e_wen});
      chk($sformatf("v%0d_isdiv", i), {31'd0, bus.wb_is_div},   {31'd0, vq[i].e_div});
      chk($sformatf("v%0d_hz", i),    {31'd0, hazard_stall},    {31'd0, vq[i].e_hz});
      chk($sformatf("v%0d_blk", i),   {31'd0, div_issue_block}, {31'd0, vq[i].e_blk});
      chk($sformatf("v%0d_hold", i),  {31'd0, pipe_hold},       {31'd0, vq[i].e_hold});
      if (vq[i].e_wen) begin
        chk($sformatf("v%0d_waddr", i), {27'd0, bus.rf_waddr}, {27'd0, vq[i].e_wa});
        chk($sformatf("v%0d_wdata", i), bus.rf_wdata, vq[i].e_wd);
        chk($sformatf("v%0d_tag", i), bus.wb_instr_tag,
            vq[i].e_wd + (vq[i].e_div ? 32'h100 : 32'h200));
        chk($sformatf("v%0d_instr", i), bus.wb_instr,
            vq[i].e_wd ^ (vq[i].e_div ? 32'hDEAD0000 : 32'hBEEF0000));
      end
    end

    // starvation: one buffered entry behind continuous pipeline writebacks
    v = idle(); v.pv = 1; v.pa = 3; v.pd = 32'h33; v.dv = 1; v.da = 12; v.dd = 32'hC;
    @(posedge clk); #1 drive(v);
    v.dv = 0; v.da = 0; v.dd = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1 drive(v);
      @(negedge clk);
      chk($sformatf("starve_hold_c%0d", k), {31'd0, pipe_hold}, {31'd0, (k >= 8)});
    end
    @(posedge clk); #1 drive(idle());
    @(negedge clk);
    chk("starve_hold_bubble", {31'd0, pipe_hold}, 32'd1);
    @(posedge clk); #1 drive(idle());
    @(negedge clk);
    chk("starve_pop_wen",   {31'd0, bus.rf_wen},    32'd1);
    chk("starve_pop_waddr", {27'd0, bus.rf_waddr},  32'd12);
    chk("starve_pop_wdata", bus.rf_wdata,           32'hC);
    chk("starve_pop_isdiv", {31'd0, bus.wb_is_div}, 32'd1);
    chk("starve_pop_hold",  {31'd0, pipe_hold},     32'd0);

    // fill buffer under pipeline writebacks; a pending divide counts toward the limit
    v = idle(); v.pv = 1; v.pa = 3; v.pd = 32'h33; v.dv = 1; v.da = 13; v.dd = 32'hD;
    @(posedge clk); #1 drive(v);
    v.dv = 0; v.da = 0; v.dd = 0; v.iss = 1; v.iss_rd = 14;
    @(posedge clk); #1 drive(v);
    @(negedge clk);
    chk("fill_blk_occ1", {31'd0, div_issue_block}, 32'd0);
    v.iss = 0; v.iss_rd = 0; v.dv = 1; v.da = 14; v.dd = 32'hE;
    @(posedge clk); #1 drive(v);
    @(negedge clk);
    chk("fill_blk_occ1_pend", {31'd0, div_issue_block}, 32'd1);
    v.dv = 0; v.da = 0; v.dd = 0; v.rs1 = 14;
    @(posedge clk); #1 drive(v);
    @(negedge clk);
    chk("fill_blk_full", {31'd0, div_issue_block}, 32'd1);
    chk("fill_hz_buf",   {31'd0, hazard_stall},    32'd1);

    // asynchronous reset mid-cycle clears everything at once
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_wen",   {31'd0, bus.rf_wen},      32'd0);
    chk("arst_waddr", {27'd0, bus.rf_waddr},    32'd0);
    chk("arst_wdata", bus.rf_wdata,             32'd0);
    chk("arst_isdiv", {31'd0, bus.wb_is_div},   32'd0);
    chk("arst_hz",    {31'd0, hazard_stall},    32'd0);
    chk("arst_blk",   {31'd0, div_issue_block}, 32'd0);
    chk("arst_hold",  {31'd0, pipe_hold},       32'd0);
    @(posedge clk); #1 rst_n = 1'b1; drive(idle());
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_wen", {31'd0, bus.rf_wen},      32'd0);
    chk("post_rst_blk", {31'd0, div_issue_block}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_wb_arb.md
Name: div_wb_arb

Overview:
- Downstream end of the divider result interface. Accepts the single-cycle, non-backpressurable result pulse (valid, data, rd address, instruction tag, instruction word) from the iterative divider.
- Arbitrates that result against the main pipeline writeback for the single register-file write port. Buffers up to DEPTH divide results.
- Keeps a scoreboard of the in-flight divide destination so decode can stall RAW/WAW hazards. Sits between EXU and the register file.

Parameters:
- XLEN, 32, width of instruction tag.
- DEPTH, 2, divide result buffer entries (power of 2, >=2).
- STARVE_LIM, 8, cycles a non-empty buffer waits before requesting a pipeline writeback bubble.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- div_issue  in  1  legal divide accepted into divider this cycle.
- div_issue_rd  in  5  destination of issuing divide.
- flush_lower  in  1  pipeline flush.
- div_out_valid  in  1  divider result pulse.
- div_out  in  32  divider result.
- div_out_addr  in  5  divider rd.
- div_instr_tag  in  XLEN  divider instruction tag.
- div_instr  in  32  divider instruction word.
- pipe_wb_valid  in  1  main pipeline writeback request.
- pipe_wb_addr  in  5  pipeline rd.
- pipe_wb_data  in  32  pipeline result.
- pipe_instr_tag  in  XLEN  pipeline tag.
- pipe_instr  in  32  pipeline instruction.
- idu_rs1_addr  in  5  decode source 1.
- idu_rs2_addr  in  5  decode source 2.
- idu_rd_addr  in  5  decode destination.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  32  write data.
- wb_instr_tag  out  XLEN  retiring tag.
- wb_instr  out  32  retiring instruction.
- wb_is_div  out  1  current write comes from the divide buffer.
- hazard_stall  out  1  decode must stall.
- div_issue_block  out  1  buffer cannot guarantee space; decode must not issue a divide.
- pipe_hold  out  1  request a one-cycle pipeline writeback bubble.

Behaviour:
- Reset (async assert, sync release): all outputs 0, buffer empty, scoreboard invalid, starve counter 0.
- Scoreboard:
  - Single entry {pend_v, pend_rd}. div_issue sets pend_v=1, pend_rd=div_issue_rd on the next edge.
  - div_out_valid clears it. flush_lower clears it, because the divider suppresses its finish on flush.
  - Simultaneous div_issue and div_out_valid: set wins.
  - Simultaneous div_issue and flush_lower: clear wins.
- Buffer:
  - FIFO with DEPTH entries of {addr, data, tag, instr}. Push on div_out_valid when div_out_addr != 0; results for x0 are dropped but still clear the scoreboard.
  - flush_lower does not touch the buffer; its entries are already committed.
  - Push into a full buffer cannot occur by construction (div_issue_block). A bench assertion flags it.
- Arbitration, evaluated each cycle:
  - A pipeline request with pipe_wb_valid=1 and pipe_wb_addr != 0 owns the port.
  - Otherwise, if the buffer is non-empty, pop the head.
  - Otherwise, if div_out_valid with a nonzero address, bypass directly without a push.
  - A pipeline request with addr 0 is treated as idle.
- Write port outputs are registered: one-cycle latency from the selected source to rf_wen/rf_waddr/rf_wdata/wb_instr_tag/wb_instr/wb_is_div. rf_wen=0 and wb_is_div=0 when idle; data fields hold their previous value.
- hazard_stall is combinational. It asserts when any of idu_rs1_addr, idu_rs2_addr or idu_rd_addr equals a nonzero address in:
  - the valid pend_rd, or
  - any valid buffer entry, or
  - the registered write stage while wb_is_div=1.
- div_issue_block is combinational: 1 when occupancy + pend_v >= DEPTH.
- Starvation:
  - The counter increments each cycle the buffer is non-empty and not popped, and resets on a pop or when the buffer is empty.
  - pipe_hold=1 when counter >= STARVE_LIM-1.
  - The pipeline must then present pipe_wb_valid=0 next cycle, guaranteeing a pop.
- Occupancy wrap: pointers are log2(DEPTH)+1 bits; full/empty are derived from MSB compare.

Test Plan:
- Pipe idle, div_issue rd=5, then div_out_valid data=0x0000_0007 addr=5 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=7, wb_is_div=1; buffer stays empty; pend_v cleared.
- pipe_wb_valid addr=3 held 4 cycles while div_out_valid addr=9 data=0x1234 arrives in cycle 1 -> pipe writes 3 every cycle; div entry buffered; written in the first idle cycle with rf_waddr=9.
- Div pending rd=7 and idu_rs2_addr=7 -> hazard_stall=1. After the result writes back and leaves the write stage -> hazard_stall=0. rd=0 pending never stalls.
- div_issue rd=4 then flush_lower next cycle, no result -> pend_v=0, hazard_stall deasserts, no register-file write.
- Buffer holds 1 entry under continuous pipe writeback -> pipe_hold=1 after 7 stalled cycles. Pipe bubbles -> entry pops, pipe_hold=0.
- Fill buffer to DEPTH=2 -> div_issue_block=1. Async rst_n low mid-operation -> all outputs 0 immediately, buffer empty.
